// File: rtl/layer_pkg.sv
// Shared types and helpers for the layered overlay fetch scheduler.
package layer_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    REQ  = 2'd2,
    WAIT = 2'd3
  } state_t;

  // The bottom edge is formed at COORD_W+1 bits so a window touching line 4095
  // (or overflowing past it) never wraps back to the top of the screen.
  function automatic logic layer_active(input logic [COORD_W-1:0] ny,
                                        input logic [COORD_W-1:0] top,
                                        input logic [COORD_W-1:0] height);
    logic [COORD_W:0] bottom;
    bottom = {1'b0, top} + {1'b0, height};
    return ({1'b0, ny} > {1'b0, top}) && ({1'b0, ny} <= bottom);
  endfunction

endpackage

// File: rtl/layer_fetch_sched_if.sv
// Fetch command channel between the scheduler and the frame-buffer read master.
interface layer_fetch_sched_if
  import layer_pkg::*;
#(
  parameter int LID_W = 2
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [LID_W-1:0]   cmd_layer;
  logic [COORD_W-1:0] cmd_row;
  logic [COORD_W-1:0] cmd_len;
  logic               cmd_done;

  modport master (
    output cmd_valid, cmd_layer, cmd_row, cmd_len,
    input  cmd_ready, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_layer, cmd_row, cmd_len,
    output cmd_ready, cmd_done
  );

endinterface

// File: rtl/layer_rr_pick.sv
// Round-robin picker: first set bit of the mask searching upward from ptr+1.
module layer_rr_pick #(
  parameter int LAYERS = 4,
  parameter int LID_W  = 2
) (
  input  logic [LAYERS-1:0] mask_i,
  input  logic [LID_W-1:0]  ptr_i,
  output logic [LID_W-1:0]  id_o,
  output logic              found_o
);

  logic [LID_W-1:0] idx;

  // Walk offsets 1..LAYERS from the pointer so the pointer's own layer is
  // considered last; the first hit wins.
  always_comb begin
    id_o    = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= LAYERS; k++) begin
      idx = LID_W'((int'(ptr_i) + k) % LAYERS);
      if (!found_o && mask_i[idx]) begin
        found_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/layer_fetch_sched.sv
// Per-line fetch scheduler: decides which overlay windows cover the next line
// and issues one line-fetch command per covered layer, one at a time.
module layer_fetch_sched
  import layer_pkg::*;
#(
  parameter int LAYERS = 4,
  parameter int LID_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        line_start,
  input  logic [COORD_W-1:0]          line_y,
  input  logic [LAYERS-1:0]           layer_en,
  input  logic [LAYERS*COORD_W-1:0]   top_in,
  input  logic [LAYERS*COORD_W-1:0]   left_in,
  input  logic [LAYERS*COORD_W-1:0]   width_in,
  input  logic [LAYERS*COORD_W-1:0]   height_in,
  layer_fetch_sched_if.master         cmd,
  output logic                        busy,
  output logic                        line_done,
  output logic                        underrun,
  input  logic                        underrun_clr
);

  state_t                     state_q, state_d;
  logic [COORD_W-1:0]         ny_q, ny_d;
  logic [LAYERS-1:0]          en_q;
  logic [LAYERS*COORD_W-1:0]  top_q, left_q, width_q, height_q;
  logic [LAYERS-1:0]          pend_q, pend_d;
  logic [LID_W-1:0]           ptr_q, ptr_d;
  logic [LID_W-1:0]           layer_q, layer_d;
  logic [COORD_W-1:0]         row_q, row_d;
  logic [COORD_W-1:0]         len_q, len_d;
  logic                       line_done_q, line_done_d;
  logic                       underrun_q, underrun_d;
  logic                       abort_q, abort_d;

  logic [LAYERS-1:0]          active_mask;
  logic [LAYERS-1:0]          clr_mask;
  logic [LAYERS-1:0]          pick_mask;
  logic [LID_W-1:0]           pick_ptr;
  logic [LID_W-1:0]           pick_id;
  logic                       pick_found;
  logic                       in_busy;
  logic                       underrun_evt;
  logic                       wait_done;
  logic [COORD_W-1:0]         sel_top;
  logic [COORD_W-1:0]         sel_width;
  logic                       left_unused;

  // The left edge is shadowed with the rest of the window so the frame stays
  // coherent, but a line fetch always covers the full width from column 0.
  assign left_unused = ^left_q;

  assign in_busy      = (state_q != IDLE);
  assign underrun_evt = in_busy && (line_start || frame_start);
  assign wait_done    = (state_q == WAIT) && cmd.cmd_done;

  // Window shadow registers, reloaded only at vsync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= '0;
      top_q    <= '0;
      left_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else if (frame_start) begin
      en_q     <= layer_en;
      top_q    <= top_in;
      left_q   <= left_in;
      width_q  <= width_in;
      height_q <= height_in;
    end
  end

  // Which enabled windows cover the latched next line.
  always_comb begin
    active_mask = '0;
    for (int i = 0; i < LAYERS; i++) begin
      active_mask[i] = en_q[i] &&
        layer_active(ny_q, top_q[i*COORD_W +: COORD_W], height_q[i*COORD_W +: COORD_W]);
    end
  end

  // Picker input: the fresh mask in EVAL, otherwise what remains after the
  // completing layer, searching from that layer onward.
  always_comb begin
    clr_mask          = '0;
    clr_mask[layer_q] = 1'b1;
    if (state_q == EVAL) begin
      pick_mask = active_mask;
      pick_ptr  = ptr_q;
    end else begin
      pick_mask = pend_q & ~clr_mask;
      pick_ptr  = layer_q;
    end
  end

  layer_rr_pick #(
    .LAYERS (LAYERS),
    .LID_W  (LID_W)
  ) u_pick (
    .mask_i  (pick_mask),
    .ptr_i   (pick_ptr),
    .id_o    (pick_id),
    .found_o (pick_found)
  );

  assign sel_top   = top_q[int'(pick_id)*COORD_W +: COORD_W];
  assign sel_width = width_q[int'(pick_id)*COORD_W +: COORD_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an underrun abandons the line but lets a shown command finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (line_start) state_d = EVAL;
      EVAL: begin
        if (underrun_evt || !pick_found) state_d = IDLE;
        else                             state_d = REQ;
      end
      REQ:  if (cmd.cmd_ready) state_d = WAIT;
      WAIT: begin
        if (cmd.cmd_done) begin
          if (underrun_evt || abort_q || !pick_found) state_d = IDLE;
          else                                        state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy          = in_busy;
    cmd.cmd_valid = (state_q == REQ);
  end

  assign cmd.cmd_layer = layer_q;
  assign cmd.cmd_row   = row_q;
  assign cmd.cmd_len   = len_q;
  assign line_done     = line_done_q;
  assign underrun      = underrun_q;

  // Datapath next values: pending mask, pointer, command fields and flags.
  always_comb begin
    ny_d        = ny_q;
    pend_d      = pend_q;
    ptr_d       = ptr_q;
    layer_d     = layer_q;
    row_d       = row_q;
    len_d       = len_q;
    line_done_d = 1'b0;

    if ((state_q == IDLE) && line_start) begin
      ny_d = line_y + COORD_W'(1);
    end

    if (state_q == EVAL) begin
      pend_d = active_mask;
    end

    if (wait_done) begin
      pend_d = pend_q & ~clr_mask;
      ptr_d  = layer_q;
    end

    if ((state_d == REQ) && (state_q != REQ)) begin
      layer_d = pick_id;
      row_d   = ny_q - sel_top - COORD_W'(1);
      len_d   = sel_width;
    end

    line_done_d = !underrun_evt && !pick_found &&
                  ((state_q == EVAL) || (wait_done && !abort_q));

    if (underrun_evt) begin
      pend_d = '0;
    end

    abort_d = (abort_q || underrun_evt) && (state_d != IDLE);

    if (underrun_evt)      underrun_d = 1'b1;
    else if (underrun_clr) underrun_d = 1'b0;
    else                   underrun_d = underrun_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ny_q        <= '0;
      pend_q      <= '0;
      ptr_q       <= LID_W'(LAYERS - 1);
      layer_q     <= '0;
      row_q       <= '0;
      len_q       <= '0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      ny_q        <= ny_d;
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      layer_q     <= layer_d;
      row_q       <= row_d;
      len_q       <= len_d;
      line_done_q <= line_done_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

endmodule

// File: tb/tb_layer_fetch_sched.sv
// Self-checking bench for layer_fetch_sched against a per-line behavioural model.
module tb_layer_fetch_sched;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        line_start;
  logic [11:0] line_y;
  logic [3:0]  layer_en;
  logic [47:0] top_in, left_in, width_in, height_in;
  logic        busy, line_done, underrun, underrun_clr;

  int checks;
  int errors;

  // Behavioural model: shadowed windows and the round-robin pointer.
  int mEn[4];
  int mTop[4];
  int mH[4];
  int mW[4];
  int mPtr;

  layer_fetch_sched_if #(.LID_W(2)) cmd_if ();

  layer_fetch_sched #(
    .LAYERS (4),
    .LID_W  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .line_y       (line_y),
    .layer_en     (layer_en),
    .top_in       (top_in),
    .left_in      (left_in),
    .width_in     (width_in),
    .height_in    (height_in),
    .cmd          (cmd_if),
    .busy         (busy),
    .line_done    (line_done),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mEn[i] = 0; mTop[i] = 0; mH[i] = 0; mW[i] = 0;
    end
    mPtr = 3;
  endtask

  task automatic setLayer(input int i, input int en, input int top, input int h, input int w);
    layer_en[i]           = en[0];
    top_in[i*12 +: 12]    = 12'(top);
    height_in[i*12 +: 12] = 12'(h);
    width_in[i*12 +: 12]  = 12'(w);
    left_in[i*12 +: 12]   = 12'($urandom_range(0, 4095));
  endtask

  task automatic commitFrame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mEn[i]  = int'(layer_en[i]);
      mTop[i] = int'(top_in[i*12 +: 12]);
      mH[i]   = int'(height_in[i*12 +: 12]);
      mW[i]   = int'(width_in[i*12 +: 12]);
    end
  endtask

  // Expected fetch order for a line: covered layers taken from pointer+1 upward.
  task automatic expectedOrder(input int y, output int ny, output int q[$]);
    int id;
    q.delete();
    ny = (y + 1) % 4096;
    for (int k = 1; k <= 4; k++) begin
      id = (mPtr + k) % 4;
      if (mEn[id] != 0 && ny > mTop[id] && ny <= mTop[id] + mH[id]) q.push_back(id);
    end
  endtask

  // Runs one whole line and checks every command, its timing and line_done.
  task automatic doLine(input int y, input int stall);
    int q[$];
    int ny;
    int id;
    logic [1:0]  expId;
    logic [11:0] expRow, expLen;
    expectedOrder(y, ny, q);
    @(negedge clk);
    line_y     = 12'(y);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cmd_if.cmd_valid !== 1'b0)
      $display("[TB] FAIL eval_cycle y=%0d: busy=%b valid=%b, expected busy=1 valid=0", y, busy, cmd_if.cmd_valid);
    @(negedge clk);
    if (q.size() == 0) begin
      checks++;
      if (line_done !== 1'b1 || cmd_if.cmd_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL empty_line y=%0d: line_done=%b valid=%b, expected 1/0", y, line_done, cmd_if.cmd_valid);
      end
    end
    while (q.size() > 0) begin
      id     = q.pop_front();
      expId  = 2'(id);
      expRow = 12'(ny - mTop[id] - 1);
      expLen = 12'(mW[id]);
      checks++;
      if (cmd_if.cmd_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL cmd_valid y=%0d: got %b expected 1", y, cmd_if.cmd_valid);
      end
      checks++;
      if (cmd_if.cmd_layer !== expId) begin
        errors++;
        $display("[TB] FAIL cmd_layer y=%0d: got %0d expected %0d", y, cmd_if.cmd_layer, expId);
      end
      checks++;
      if (cmd_if.cmd_row !== expRow) begin
        errors++;
        $display("[TB] FAIL cmd_row y=%0d layer=%0d: got %0d expected %0d", y, id, cmd_if.cmd_row, expRow);
      end
      checks++;
      if (cmd_if.cmd_len !== expLen) begin
        errors++;
        $display("[TB] FAIL cmd_len y=%0d layer=%0d: got %0d expected %0d", y, id, cmd_if.cmd_len, expLen);
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++;
        if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_layer !== expId ||
            cmd_if.cmd_row !== expRow || cmd_if.cmd_len !== expLen) begin
          errors++;
          $display("[TB] FAIL stall_stable cycle %0d: valid=%b layer=%0d row=%0d len=%0d expected 1/%0d/%0d/%0d",
                   s, cmd_if.cmd_valid, cmd_if.cmd_layer, cmd_if.cmd_row, cmd_if.cmd_len, expId, expRow, expLen);
        end
      end
      cmd_if.cmd_ready = 1'b1;
      @(negedge clk);
      cmd_if.cmd_ready = 1'b0;
      checks++;
      if (cmd_if.cmd_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL after_accept: valid=%b busy=%b expected 0/1", cmd_if.cmd_valid, busy);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cmd_if.cmd_done = 1'b1;
      @(negedge clk);
      cmd_if.cmd_done = 1'b0;
      mPtr = id;
      if (q.size() == 0) begin
        checks++;
        if (line_done !== 1'b1 || busy !== 1'b0 || cmd_if.cmd_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL line_end y=%0d: line_done=%b busy=%b valid=%b expected 1/0/0",
                   y, line_done, busy, cmd_if.cmd_valid);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (line_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL line_done_pulse y=%0d: line_done=%b busy=%b expected 0/0", y, line_done, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_valid !== 1'b0 || busy !== 1'b0 || line_done !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: valid=%b busy=%b line_done=%b underrun=%b expected all 0",
               cmd_if.cmd_valid, busy, line_done, underrun);
    end
    checks++;
    if (cmd_if.cmd_layer !== 2'd0 || cmd_if.cmd_row !== 12'd0 || cmd_if.cmd_len !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_fields: layer=%0d row=%0d len=%0d expected 0", cmd_if.cmd_layer, cmd_if.cmd_row, cmd_if.cmd_len);
    end
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) setLayer(i, 0, 0, 0, 0);
    setLayer(0, 1, 10, 5, 100);
    setLayer(1, 1, 12, 2, 64);
    commitFrame();
    doLine(11, 0);
  endtask

  task automatic test_rotation();
    doLine(12, 0);
    doLine(13, 0);
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < 4; i++) setLayer(i, 0, 0, 0, 0);
    setLayer(0, 1, 4095, 1, 33);
    commitFrame();
    doLine(4094, 0);
    doLine(4095, 0);
    setLayer(0, 1, 0, 4095, 77);
    commitFrame();
    doLine(4094, 0);
    doLine(4093, 0);
    doLine(4095, 0);
  endtask

  task automatic test_underrun();
    int q[$];
    int ny;
    for (int i = 0; i < 4; i++) setLayer(i, 0, 0, 0, 0);
    setLayer(0, 1, 10, 5, 100);
    setLayer(1, 1, 12, 2, 64);
    commitFrame();
    expectedOrder(12, ny, q);
    @(negedge clk);
    line_y     = 12'd12;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_layer !== 2'(q[0])) begin
      errors++;
      $display("[TB] FAIL underrun_first_cmd: valid=%b layer=%0d expected 1/%0d", cmd_if.cmd_valid, cmd_if.cmd_layer, q[0]);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    line_start       = 1'b1;
    underrun_clr     = 1'b1;
    @(negedge clk);
    line_start   = 1'b0;
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underrun_set: underrun=%b busy=%b expected 1/1", underrun, busy);
    end
    cmd_if.cmd_done = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b0;
    mPtr = q[0];
    checks++;
    if (busy !== 1'b0 || line_done !== 1'b0 || cmd_if.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underrun_abort: busy=%b line_done=%b valid=%b expected 0/0/0", busy, line_done, cmd_if.cmd_valid);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (cmd_if.cmd_valid !== 1'b0 || line_done !== 1'b0 || underrun !== 1'b1) begin
        errors++;
        $display("[TB] FAIL underrun_quiet cycle %0d: valid=%b line_done=%b underrun=%b expected 0/0/1",
                 c, cmd_if.cmd_valid, line_done, underrun);
      end
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underrun_clear: got %b expected 0", underrun);
    end
    doLine(12, 0);
  endtask

  task automatic test_stall();
    doLine(13, 5);
  endtask

  task automatic test_reset_mid_req();
    for (int i = 0; i < 4; i++) setLayer(i, 1, 0, 100, 20 + i);
    commitFrame();
    @(negedge clk);
    line_y     = 12'd5;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    checks++;
    if (underrun !== 1'b1 || cmd_if.cmd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_underrun_hold: underrun=%b valid=%b expected 1/1", underrun, cmd_if.cmd_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cmd_if.cmd_valid !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b busy=%b underrun=%b expected 0/0/0", cmd_if.cmd_valid, busy, underrun);
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    commitFrame();
    doLine(5, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 48; n++) begin
      if (n % 8 == 0) begin
        for (int i = 0; i < 4; i++)
          setLayer(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
                   int'($urandom_range(0, 8)), int'($urandom_range(1, 4095)));
        commitFrame();
      end
      doLine(int'($urandom_range(0, 30)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    frame_start      = 1'b0;
    line_start       = 1'b0;
    line_y           = '0;
    layer_en         = '0;
    top_in           = '0;
    left_in          = '0;
    width_in         = '0;
    height_in        = '0;
    underrun_clr     = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    cmd_if.cmd_done  = 1'b0;
    modelReset();

    test_reset();
    test_single();
    test_rotation();
    test_boundaries();
    test_underrun();
    test_stall();
    test_reset_mid_req();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
